// File: rtl/pwmer_gen.sv
// pwmer_gen: single-bit PWM DAC modulator. Signed N-bit samples become offset-binary duty
// values, loaded once per 2^N-clock period and compared against a free-running counter.
module pwmer_gen #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         areset,
   input  logic [N-1:0] din,
   output logic         pwmout
);

   localparam logic [N-1:0] MIDSCALE = {1'b1, {(N-1){1'b0}}};

   logic [N-1:0] cnt_reg;
   logic [N-1:0] cnt_next;
   logic [N-1:0] duty_reg;
   logic [N-1:0] duty_next;
   logic         pwmout_reg;
   logic         pwmout_next;
   logic [N-1:0] offset;
   logic         wrap;

   // Two's complement to offset binary is just an MSB flip.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_offset
         if (gi == N - 1) begin : g_msb
            assign offset[gi] = ~din[gi];
         end else begin : g_lsb
            assign offset[gi] = din[gi];
         end
      end
   endgenerate

   assign wrap = &cnt_reg;

   always_comb begin
      cnt_next    = cnt_reg + 1'b1;
      duty_next   = wrap ? offset : duty_reg;
      pwmout_next = (cnt_reg < duty_reg);
   end

   always_ff @(posedge clk) begin
      if (!areset) begin
         cnt_reg    <= '0;
         duty_reg   <= MIDSCALE;
         pwmout_reg <= 1'b0;
      end else begin
         cnt_reg    <= cnt_next;
         duty_reg   <= duty_next;
         pwmout_reg <= pwmout_next;
      end
   end

   assign pwmout = pwmout_reg;

endmodule

// File: tb/tb_pwmer_gen.sv
// Self-checking bench for pwmer_gen: N=8 and N=4 instances checked cycle by cycle against a
// period-indexed reference model, plus table-driven duty tests and hand-written corner cases.
module tb_pwmer_gen;

   logic       clk = 1'b0;
   logic       areset;
   logic [7:0] din8;
   logic [3:0] din4;
   logic       pwm8;
   logic       pwm4;

   int errors = 0;
   int checks = 0;

   // Model: edges since reset release, and the duty of each period (index = period number).
   int e8, e4;
   int pd8[$];
   int pd4[$];

   typedef struct {
      bit         is4;
      logic [7:0] din;
      int         high;
   } vec_t;
   vec_t tab[10];

   always #5 clk = ~clk;

   pwmer_gen #(.N(8)) dut8 (.clk(clk), .areset(areset), .din(din8), .pwmout(pwm8));
   pwmer_gen #(.N(4)) dut4 (.clk(clk), .areset(areset), .din(din4), .pwmout(pwm4));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: capture inputs seen at the edge, advance, then compare both outputs.
   task automatic tick();
      logic [7:0] d8;
      logic [3:0] d4;
      logic       r;
      int         exp8, exp4, pos;
      d8 = din8;
      d4 = din4;
      r  = areset;
      @(posedge clk);
      #1;
      if (!r) begin
         e8 = 0; e4 = 0;
         pd8.delete(); pd4.delete();
         pd8.push_back(128);
         pd4.push_back(8);
         exp8 = 0; exp4 = 0;
      end else begin
         pos  = e8 % 256;
         exp8 = (pos < pd8[e8 / 256]) ? 1 : 0;
         if (pos == 255) pd8.push_back(int'(d8) ^ 128);
         e8++;
         pos  = e4 % 16;
         exp4 = (pos < pd4[e4 / 16]) ? 1 : 0;
         if (pos == 15) pd4.push_back(int'(d4) ^ 8);
         e4++;
      end
      chk($sformatf("wave8 e=%0d", e8), {31'd0, pwm8}, exp8);
      chk($sformatf("wave4 e=%0d", e4), {31'd0, pwm4}, exp4);
   endtask

   // Run until the edge that just happened was a wrap edge of the chosen instance.
   task automatic align(input bit is4);
      int guard = 0;
      do begin
         tick();
         guard++;
      end while ((((is4 ? e4 : e8) % (is4 ? 16 : 256)) != 0) && guard < 600);
      if (guard >= 600) chk("align_timeout", guard, 0);
   endtask

   task automatic count_high(input bit is4, input int n, output int highs);
      highs = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         highs += ((is4 ? pwm4 : pwm8) === 1'b1) ? 1 : 0;
      end
   endtask

   initial begin
      int h, h2;
      tab[0] = '{1'b0, 8'h00, 128};
      tab[1] = '{1'b0, 8'h80, 0};
      tab[2] = '{1'b0, 8'h7F, 255};
      tab[3] = '{1'b0, 8'h40, 192};
      tab[4] = '{1'b0, 8'hC0, 64};
      tab[5] = '{1'b0, 8'h01, 129};
      tab[6] = '{1'b1, 8'h08, 0};
      tab[7] = '{1'b1, 8'h03, 11};
      tab[8] = '{1'b1, 8'h07, 15};
      tab[9] = '{1'b1, 8'h00, 8};

      // Reset held two clocks, then the first period is midscale regardless of din.
      areset = 1'b0;
      din8   = 8'h55;
      din4   = 4'h5;
      tick();
      tick();
      chk("reset_pwm8", {31'd0, pwm8}, 0);
      chk("reset_pwm4", {31'd0, pwm4}, 0);
      areset = 1'b1;
      count_high(1'b0, 256, h);
      chk("first_period_high8", h, 128);

      // Constant din: four periods of midscale.
      din8 = 8'h00;
      align(1'b0);
      for (int p = 0; p < 4; p++) begin
         count_high(1'b0, 256, h);
         chk($sformatf("const0_period%0d", p), h, 128);
      end

      // Table of duty values for both widths.
      foreach (tab[i]) begin
         if (tab[i].is4) din4 = tab[i].din[3:0];
         else            din8 = tab[i].din;
         align(tab[i].is4);
         count_high(tab[i].is4, tab[i].is4 ? 16 : 256, h);
         chk($sformatf("table%0d din=%0h", i, tab[i].din), h, tab[i].high);
         count_high(tab[i].is4, tab[i].is4 ? 16 : 256, h);
         chk($sformatf("table%0d_repeat", i), h, tab[i].high);
      end

      // din change mid-period does not affect the running period.
      din8 = 8'h00;
      align(1'b0);
      count_high(1'b0, 100, h);
      din8 = 8'h40;
      count_high(1'b0, 156, h2);
      chk("midchange_current", h + h2, 128);
      count_high(1'b0, 256, h);
      chk("midchange_next", h, 192);

      // Reset at cnt=60 while duty=192: output drops, period restarts at midscale.
      count_high(1'b0, 60, h);
      chk("pre_reset_high", h, 60);
      areset = 1'b0;
      tick();
      chk("midreset_pwm8", {31'd0, pwm8}, 0);
      areset = 1'b1;
      count_high(1'b0, 256, h);
      chk("post_reset_high", h, 128);
      count_high(1'b0, 256, h);
      chk("post_reset_next", h, 192);

      // Random samples changing every 50 clocks, checked every cycle by the model.
      for (int s = 0; s < 300; s++) begin
         din8 = 8'($urandom);
         din4 = 4'($urandom);
         for (int c = 0; c < 50; c++) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
